// File: rtl/ecc_scalar_mul_ctrl_if.sv
// Bundle for the scalar-multiply sequencer: the job side (start/k/p_in -> busy/done/result)
// and the request side towards the shared point add/double unit.
interface ecc_scalar_mul_ctrl_if;
  logic         start;
  logic [63:0]  k;
  logic [128:0] p_in;
  logic         busy;
  logic         done;
  logic [128:0] result;
  logic         ad_enable;
  logic [1:0]   ad_op;
  logic [128:0] ad_p;
  logic [128:0] ad_q;
  logic [128:0] ad_T;
  logic         ad_done;

  // Handshakes: start is a one-cycle request honoured only while busy is low; done is a
  // one-cycle pulse with result valid. ad_enable is a one-cycle request; ad_op/ad_p/ad_q
  // hold from ad_enable until the unit answers with a one-cycle ad_done carrying ad_T.
  modport slave (
    input  start, k, p_in, ad_T, ad_done,
    output busy, done, result, ad_enable, ad_op, ad_p, ad_q
  );

  modport master (
    output start, k, p_in, ad_T, ad_done,
    input  busy, done, result, ad_enable, ad_op, ad_p, ad_q
  );
endinterface

// File: rtl/ecc_scalar_mul_ctrl.sv
// Left-to-right double-and-add sequencer: walks the scalar from its leading one downwards,
// issuing one double (and an add for each set bit) to the shared add/double unit.
module ecc_scalar_mul_ctrl (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  ecc_scalar_mul_ctrl_if.slave io_bus,
  output logic [2:0]           o_dbg_state
);
  localparam int         KW     = 64;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_DBL = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_DBL_REQ  = 3'd2,
    S_DBL_WAIT = 3'd3,
    S_ADD_REQ  = 3'd4,
    S_ADD_WAIT = 3'd5,
    S_FIN      = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [KW-1:0] r_kr;
  logic [128:0]  r_pr;
  logic [128:0]  r_acc;
  logic [128:0]  r_result;
  logic [5:0]    r_idx;
  logic [5:0]    w_msb;
  logic          w_trivial;
  logic          w_kbit;

  // Leading-one detect: the highest set bit wins because it is visited last.
  always_comb begin
    w_msb = '0;
    for (int i = 0; i < KW; i++) begin
      if (r_kr[i]) w_msb = 6'(i);
    end
  end

  assign w_trivial   = (r_kr == '0) || r_pr[128];
  assign w_kbit      = r_kr[r_idx];
  assign o_dbg_state = r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (io_bus.start) w_next = S_LOAD;
      S_LOAD:     w_next = (w_trivial || (w_msb == 6'd0)) ? S_FIN : S_DBL_REQ;
      S_DBL_REQ:  w_next = S_DBL_WAIT;
      S_DBL_WAIT: begin
        if (io_bus.ad_done) begin
          if (w_kbit)              w_next = S_ADD_REQ;
          else if (r_idx == 6'd0)  w_next = S_FIN;
          else                     w_next = S_DBL_REQ;
        end
      end
      S_ADD_REQ:  w_next = S_ADD_WAIT;
      S_ADD_WAIT: begin
        if (io_bus.ad_done) w_next = (r_idx == 6'd0) ? S_FIN : S_DBL_REQ;
      end
      S_FIN:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // The index only steps down once the bit it points at has been fully consumed:
  // after its double when the bit is clear, after its add when the bit is set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_kr     <= '0;
      r_pr     <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_kr <= io_bus.k;
            r_pr <= io_bus.p_in;
          end
        end
        S_LOAD: begin
          if (w_trivial) begin
            r_acc <= {1'b1, 128'd0};
          end else begin
            r_acc <= r_pr;
            r_idx <= (w_msb == 6'd0) ? 6'd0 : w_msb - 6'd1;
          end
        end
        S_DBL_WAIT: begin
          if (io_bus.ad_done) begin
            r_acc <= io_bus.ad_T;
            if (!w_kbit && (r_idx != 6'd0)) r_idx <= r_idx - 6'd1;
          end
        end
        S_ADD_WAIT: begin
          if (io_bus.ad_done) begin
            r_acc <= io_bus.ad_T;
            if (r_idx != 6'd0) r_idx <= r_idx - 6'd1;
          end
        end
        S_FIN:   r_result <= r_acc;
        default: ;
      endcase
    end
  end

  // Result is presented straight from the accumulator in the done cycle, then held.
  always_comb begin
    io_bus.busy      = (r_state != S_IDLE);
    io_bus.done      = (r_state == S_FIN);
    io_bus.result    = (r_state == S_FIN) ? r_acc : r_result;
    io_bus.ad_enable = 1'b0;
    io_bus.ad_op     = OP_ADD;
    io_bus.ad_p      = '0;
    io_bus.ad_q      = '0;
    unique case (r_state)
      S_DBL_REQ, S_DBL_WAIT: begin
        io_bus.ad_enable = (r_state == S_DBL_REQ);
        io_bus.ad_op     = OP_DBL;
        io_bus.ad_p      = r_acc;
        io_bus.ad_q      = r_acc;
      end
      S_ADD_REQ, S_ADD_WAIT: begin
        io_bus.ad_enable = (r_state == S_ADD_REQ);
        io_bus.ad_op     = OP_ADD;
        io_bus.ad_p      = r_acc;
        io_bus.ad_q      = r_pr;
      end
      default: ;
    endcase
  end
endmodule
